// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: FSM encoding and frame constants shared by the loader.
package instr_loader_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;
  localparam int LEN_BYTES     = 2;
  localparam int CHK_BYTES     = 1;
  localparam int MEM_BYTES_DEF = 128;
endpackage

// File: rtl/instr_loader_csum.sv
// instr_loader_csum: 8-bit XOR accumulator with synchronous clear and enable.
module instr_loader_csum
  import instr_loader_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= q ^ d;
endmodule

// File: rtl/instr_loader.sv
// instr_loader: loads a length/payload/checksum byte frame into instruction memory and releases the CPU.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_clrn,
  output logic              done,
  output logic              err,
  output logic [8:0]        bytes_loaded
);
  state_t      state, nxt;
  logic [15:0] len, l_new;
  logic [8:0]  cnt;
  logic [7:0]  csum;
  logic        fire, go, wr, last, bad;
  assign in_ready     = state inside {LEN_HI, LEN_LO, DATA, CHK};
  assign fire         = in_valid && in_ready;
  assign go           = start && (state inside {IDLE, DONE, ERR});
  assign wr           = fire && state == DATA;
  assign l_new        = {len[15:8], in_data};
  assign bad          = l_new > 16'(MEM_BYTES) || l_new[1:0] != 2'b00;
  assign last         = {7'd0, cnt} + 16'd1 == len;
  assign bytes_loaded = cnt;
  instr_loader_csum u_csum (
    .clk  (clk),
    .clrn (clrn),
    .clr  (go),
    .en   (wr),
    .d    (in_data),
    .q    (csum)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: if (go) nxt = LEN_HI;
      LEN_HI:          if (fire) nxt = LEN_LO;
      LEN_LO:          if (fire) nxt = bad ? ERR : (l_new == 16'd0 ? CHK : DATA);
      DATA:            if (fire && last) nxt = CHK;
      CHK:             if (fire) nxt = in_data == csum ? DONE : ERR;
      default:         nxt = IDLE;
    endcase
  end
  // status outputs are registered from the next state so they appear in the first cycle of DONE/ERR
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state     <= IDLE;
      len       <= '0;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_clrn  <= 1'b0;
    end else begin
      state    <= nxt;
      done     <= nxt == DONE;
      err      <= nxt == ERR;
      cpu_clrn <= nxt == DONE;
      mem_we   <= wr;
      if (wr) begin
        mem_addr  <= cnt[ADDR_W-1:0];
        mem_wdata <= in_data;
      end
      if (go) cnt <= '0;
      else if (wr) cnt <= cnt + 9'd1;
      if (fire && state == LEN_HI) len[15:8] <= in_data;
      if (fire && state == LEN_LO) len[7:0] <= in_data;
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: table-driven frame loads plus restart, reset and full-size corner sequences.
module tb_instr_loader;
  logic       clk = 0, clrn = 0, start = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic       in_ready, mem_we, cpu_clrn, done, err;
  logic [7:0] mem_addr, mem_wdata;
  logic [8:0] bytes_loaded;

  instr_loader dut (
    .clk          (clk),
    .clrn         (clrn),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_clrn     (cpu_clrn),
    .done         (done),
    .err          (err),
    .bytes_loaded (bytes_loaded)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [15:0] wq[$];

  always @(negedge clk) if (mem_we) wq.push_back({mem_addr, mem_wdata});

  typedef struct {
    logic [95:0] fr;
    int          n;
    bit          stall;
    int          nw;
    logic        done;
    logic        err;
  } vec_t;

  vec_t v[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] fb(input vec_t x, input int i);
    return x.fr[8*(x.n-1-i) +: 8];
  endfunction

  task automatic send(input logic [7:0] b, input bit stall);
    int t = 0;
    if (stall) begin
      in_valid = 0;
      in_data  = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: in_ready 0 after %0d cycles, required 1", t);
    end
    in_data  = b;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run_vec(input vec_t x, input string nm, input int inj);
    pulse_start();
    wq.delete();
    for (int i = 0; i < x.n; i++) begin
      if (i == inj) pulse_start();
      send(fb(x, i), x.stall);
    end
    repeat (3) @(negedge clk);
    chk({nm, "_nwrites"}, wq.size(), x.nw);
    for (int i = 0; i < x.nw; i++)
      if (i < wq.size()) chk({nm, "_write"}, wq[i], {i[7:0], fb(x, 2 + i)});
    chk({nm, "_done"}, done, x.done);
    chk({nm, "_err"}, err, x.err);
    chk({nm, "_cpu_clrn"}, cpu_clrn, x.done);
    chk({nm, "_bytes_loaded"}, bytes_loaded, x.nw);
    chk({nm, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    logic [7:0] b, x;
    v[0] = '{96'h00083c010000342400507d, 11, 1'b0, 8, 1'b1, 1'b0};
    v[1] = '{96'h00083c010000342400507c, 11, 1'b0, 8, 1'b0, 1'b1};
    v[2] = '{96'h0084, 2, 1'b0, 0, 1'b0, 1'b1};
    v[3] = '{96'h0006, 2, 1'b0, 0, 1'b0, 1'b1};
    v[4] = '{96'h000000, 3, 1'b0, 0, 1'b1, 1'b0};
    v[5] = '{96'h000001, 3, 1'b0, 0, 1'b0, 1'b1};
    v[6] = '{96'h00083c010000342400507d, 11, 1'b1, 8, 1'b1, 1'b0};
    v[7] = '{96'h0004deadbeef22, 7, 1'b0, 4, 1'b1, 1'b0};
    v[8] = '{96'h0100, 2, 1'b0, 0, 1'b0, 1'b1};

    #2;
    chk("rst_cpu_clrn", cpu_clrn, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_bytes_loaded", bytes_loaded, 0);
    @(negedge clk);
    clrn = 1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);

    for (int k = 0; k < 9; k++) run_vec(v[k], $sformatf("vec%0d", k), -1);

    run_vec(v[0], "mid_start", 5);

    pulse_start();
    wq.delete();
    for (int i = 0; i < 5; i++) send(fb(v[0], i), 1'b0);
    chk("rst_mid_we_pending", mem_we, 1);
    #1 clrn = 0;
    #1;
    chk("rst_mid_mem_we", mem_we, 0);
    chk("rst_mid_cpu_clrn", cpu_clrn, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_err", err, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    chk("rst_mid_bytes_loaded", bytes_loaded, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    chk("rst_mid_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    clrn = 1;
    @(negedge clk);
    chk("rst_mid_idle", in_ready, 0);
    run_vec(v[0], "after_rst", -1);

    pulse_start();
    wq.delete();
    send(8'h00, 1'b0);
    send(8'h80, 1'b0);
    x = 0;
    for (int i = 0; i < 128; i++) begin
      b = 8'(i * 5 + 1);
      x ^= b;
      send(b, 1'b0);
    end
    send(x, 1'b0);
    repeat (3) @(negedge clk);
    chk("full_nwrites", wq.size(), 128);
    for (int i = 0; i < 128; i++)
      if (i < wq.size()) chk("full_write", wq[i], {i[7:0], 8'(i * 5 + 1)});
    chk("full_done", done, 1);
    chk("full_err", err, 0);
    chk("full_cpu_clrn", cpu_clrn, 1);
    chk("full_bytes_loaded", bytes_loaded, 128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the byte-addressed, big-endian instruction memory. The CPU only ever reads that memory through its PC port.
- Receives a framed byte stream over a valid/ready handshake and writes the payload bytes into the memory's byte write port, starting at address 0.
- Holds the CPU in reset until a frame has loaded and its checksum has verified.
- Sits between the host/UART byte source and the instruction memory write port.

Parameters:
- MEM_BYTES, 128, instruction memory size in bytes. Must be a power of two and at most 256.
- ADDR_W, 8, width of mem_addr. Matches the 8-bit byte index the PC read port uses.

Ports:
- clk  input  1  system clock, rising edge.
- clrn  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a load.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  byte write strobe to instruction memory.
- mem_addr  output  ADDR_W  byte address of the write.
- mem_wdata  output  8  byte to write.
- cpu_clrn  output  1  active-low reset to the CPU core.
- done  output  1  load completed and checksum verified.
- err  output  1  load aborted on a length or checksum error.
- bytes_loaded  output  9  count of payload bytes written.

Behaviour:
- Reset (clrn=0, asynchronous): every output is 0, including cpu_clrn, so the CPU is held in reset. State goes to IDLE; counters and the checksum register clear.
- Handshake: a byte transfers on a rising edge where in_valid and in_ready are both 1.
  - in_ready is 1 only in LEN_HI, LEN_LO, DATA and CHK.
  - in_ready is a function of state only, never of in_valid.
- Frame format, in order:
  - Length high byte, then length low byte: a 16-bit big-endian payload length L.
  - L payload bytes, which are memory bytes 0..L-1 in big-endian instruction order.
  - One checksum byte equal to the XOR of all payload bytes.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
- IDLE:
  - start moves to LEN_HI.
  - On that same edge: cpu_clrn goes to 0, done and err go to 0, and bytes_loaded, the address and the checksum clear.
- LEN_HI: on transfer, latch L[15:8] and move to LEN_LO.
- LEN_LO: on transfer, latch L[7:0], then branch:
  - Next state is ERR if L > MEM_BYTES or L[1:0] != 0 (whole instructions only).
  - Otherwise the next state is CHK if L == 0.
  - Otherwise the next state is DATA.
- DATA: on each transfer:
  - Register mem_wdata = in_data and mem_addr = the current byte counter.
  - Assert mem_we for exactly the next cycle (1-cycle write latency).
  - XOR the byte into the checksum.
  - Increment the counter and bytes_loaded.
  - After byte L-1 is accepted, move to CHK.
- mem_we is 0 in every cycle that does not follow a DATA transfer. Stalls (in_valid=0) insert no writes.
- CHK: on transfer, go to DONE if in_data equals the checksum, otherwise go to ERR.
- DONE: done=1 and cpu_clrn=1, both registered and asserted from the first DONE cycle.
- ERR: err=1 and cpu_clrn stays 0. Bytes already written stay in memory; no rollback.
- Restart: start in DONE or ERR behaves as in IDLE. start in any other state is ignored.
- Address wrap cannot occur, because L ≤ MEM_BYTES is enforced before any write.
- Reset mid-load: the FSM aborts immediately.
  - A mem_we pending in that cycle is cancelled.
  - Memory contents are undefined and must be reloaded.

Decomposition:
- Shared package holds:
  - the FSM state encoding (3-bit localparams);
  - frame constants: LEN_BYTES=2, CHK_BYTES=1;
  - the default MEM_BYTES of 128.
- Natural sub-module: instr_loader_csum, an 8-bit XOR accumulator with clear and enable. The rest is a single FSM plus datapath in instr_loader.

Test Plan:
- Nominal load: start, then stream 00 08 3c 01 00 00 34 24 00 50 7d.
  - Expect 8 writes at addr 0..7 with data 3c 01 00 00 34 24 00 50.
  - Expect done=1, cpu_clrn=1, bytes_loaded=8, err=0.
- Bad checksum: same stream with a final byte of 7c.
  - Expect 8 writes.
  - Expect err=1, done=0, cpu_clrn=0.
- Length violations:
  - Header 00 84 (132 > 128) gives ERR right after LEN_LO, with zero mem_we pulses.
  - Header 00 06 (not a multiple of 4) also gives ERR with zero writes.
- Zero length: stream 00 00 00.
  - Expect done=1 with no writes.
  - Header 00 00 followed by checksum 01 instead gives err=1.
- Backpressure and stalls:
  - Drop in_valid randomly during the nominal load; expect an identical write sequence with one mem_we per byte.
  - start pulsed mid-DATA is ignored.
- Reset mid-load: assert clrn=0 after 3 payload bytes.
  - Expect all outputs 0 asynchronously and the state back to IDLE.
  - A subsequent full nominal load completes with done=1.
